// File: rtl/pp_column_accumulator.sv
// Sequential final adder for an N x N unsigned array multiplier.
// Takes every partial-product bit a[i] & b[j], grouped by column weight, and
// reduces one column per cycle (LSB column first) through a carry register.
// The result is the 2N-bit product.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   in_valid  - pp_bits holds a partial-product set
//   in_ready  - block is idle and can accept a set
//   pp_bits   - partial products; column w is a contiguous field of height
//               min(w, 2N-2-w)+1, LSB column at bit 0; only popcount matters
//   out_valid - product holds the final result
//   out_ready - consumer takes the product
//   product   - unsigned 2N-bit product
//   busy      - columns are being reduced
module pp_column_accumulator #(
  parameter int unsigned N   = 10,
  parameter int unsigned PPW = N * N,
  parameter int unsigned CW  = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [PPW-1:0] pp_bits,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int unsigned NCol = 2 * N - 1;
  localparam int unsigned IW   = $clog2(NCol);
  localparam int unsigned SW   = CW + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  function automatic int unsigned col_h(int unsigned w);
    int unsigned m;
    m = (w < NCol - 1 - w) ? w : NCol - 1 - w;
    return m + 1;
  endfunction

  function automatic int unsigned col_off(int unsigned w);
    int unsigned s;
    s = 0;
    for (int unsigned v = 0; v < w; v++) s += col_h(v);
    return s;
  endfunction

  // Popcount of the h-bit field starting at off; off/h are elaboration constants.
  function automatic logic [CW-1:0] field_pop(logic [PPW-1:0] v, int unsigned off,
                                              int unsigned h);
    logic [PPW-1:0] t;
    logic [CW-1:0]  c;
    t = v >> off;
    c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (k < h) c = c + CW'(t[k]);
    end
    return c;
  endfunction

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  carry_q, carry_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [PPW-1:0] pp_q, pp_d;

  logic [CW-1:0]  col_cnt [NCol];
  logic [SW-1:0]  col_sum;

  for (genvar w = 0; w < NCol; w++) begin : g_col
    assign col_cnt[w] = field_pop(pp_q, col_off(w), col_h(w));
  end

  // Carry is bounded by N-1, so the sum fits in CW+1 bits.
  assign col_sum = {1'b0, col_cnt[idx_q]} + {1'b0, carry_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    prod_d  = prod_q;
    pp_d    = pp_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          pp_d    = pp_bits;
          carry_d = '0;
          prod_d  = '0;
          idx_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        prod_d[idx_q] = col_sum[0];
        carry_d       = col_sum[SW-1:1];
        idx_d         = idx_q + 1'b1;
        if (idx_q == IW'(NCol - 1)) begin
          // Final carry is at most 1 since the product fits in 2N bits.
          prod_d[2*N-1] = col_sum[1];
          state_d       = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= '0;
      prod_q  <= '0;
      pp_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      prod_q  <= prod_d;
      pp_q    <= pp_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StBusy);
  assign out_valid = (state_q == StDone);
  assign product   = prod_q;

endmodule

// File: tb/tb_pp_column_accumulator.sv
module tb_pp_column_accumulator;
  localparam int unsigned N   = 10;
  localparam int unsigned PPW = N * N;
  localparam int unsigned PW  = 2 * N;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [PPW-1:0] pp_bits;
  logic           out_valid;
  logic           out_ready;
  logic [PW-1:0]  product;
  logic           busy;

  always #5 clk = ~clk;

  pp_column_accumulator #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pp_bits  (pp_bits),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Build the partial-product bus: for each weight w, all pairs i+j=w, packed
  // contiguously, LSB column first.
  function automatic logic [PPW-1:0] pack(logic [N-1:0] a, logic [N-1:0] b);
    logic [PPW-1:0] p;
    int pos;
    p   = '0;
    pos = 0;
    for (int w = 0; w < 2 * N - 1; w++) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = w - i;
        if (j >= 0 && j < N) begin
          p[pos] = a[i] & b[j];
          pos++;
        end
      end
    end
    return p;
  endfunction

  logic [N-1:0] cur_a, cur_b;

  task automatic set_in(logic v, logic [N-1:0] a, logic [N-1:0] b);
    in_valid = v;
    cur_a    = a;
    cur_b    = b;
    pp_bits  = pack(a, b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Protocol-level reference: idle/busy/done phases, result = a*b of the
  // operands presented at the accepting edge.
  int          m_state = -1;
  int          m_cnt   = 0;
  logic [63:0] m_exp   = '0;
  int          n_acc   = 0;
  int          n_res   = 0;

  always @(negedge clk) begin
    if (m_state >= 0) begin
      check("in_ready", 64'(in_ready), 64'(m_state == 0));
      check("busy", 64'(busy), 64'(m_state == 1));
      check("out_valid", 64'(out_valid), 64'(m_state == 2));
      if (m_state == 2) check("product", 64'(product), m_exp);
    end
    if (rst) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          m_state = 1;
          m_cnt   = 0;
          m_exp   = 64'(cur_a) * 64'(cur_b);
          n_acc++;
        end
        1: begin
          m_cnt++;
          if (m_cnt == 2 * N - 1) m_state = 2;
        end
        2: if (out_ready) begin
          m_state = 0;
          n_res++;
        end
        default: ;
      endcase
    end
  end

  task automatic wait_out(string name);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check(name, 64'(out_valid), 64'd1);
  endtask

  task automatic run_op(logic [N-1:0] a, logic [N-1:0] b, output logic [63:0] got,
                        output int lat);
    tick();
    set_in(1'b1, a, b);
    out_ready = 1'b1;
    @(negedge clk);
    check("ready_before_accept", 64'(in_ready), 64'd1);
    tick();
    set_in(1'b0, N'(0), N'(0));
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c - 1;
        break;
      end
    end
    if (lat < 0) check("out_valid_timeout", 64'(out_valid), 64'd1);
    got = 64'(product);
    tick();
    @(negedge clk);
    check("ready_after_out", 64'(in_ready), 64'd1);
    check("valid_after_out", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  logic [63:0] got;
  int          lat;
  logic        rnd_done;
  int          acc0, res0;

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    set_in(1'b0, N'(0), N'(0));
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_product", 64'(product), 64'd0);

    // All partial-product bits set.
    run_op(N'(1023), N'(1023), got, lat);
    check("prod_1023x1023", got, 64'd1046529);
    check("latency", 64'(lat), 64'd19);
    run_op(N'(0), N'(777), got, lat);
    check("prod_0x777", got, 64'd0);
    run_op(N'(1), N'(1), got, lat);
    check("prod_1x1", got, 64'd1);
    run_op(N'(1023), N'(1), got, lat);
    check("prod_1023x1", got, 64'd1023);

    // Consumer stalls in DONE while new inputs are offered.
    tick();
    set_in(1'b1, N'(100), N'(200));
    out_ready = 1'b0;
    tick();
    set_in(1'b0, N'(0), N'(0));
    wait_out("stall_out_timeout");
    for (int i = 0; i < 10; i++) begin
      tick();
      set_in(((i % 2) == 0), N'($urandom_range(0, 1023)), N'($urandom_range(0, 1023)));
      @(negedge clk);
      check("stall_product", 64'(product), 64'd20000);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    tick();
    out_ready = 1'b1;
    set_in(1'b1, N'(12), N'(13));
    tick();
    @(negedge clk);
    check("post_handshake_in_ready", 64'(in_ready), 64'd1);
    check("post_handshake_out_valid", 64'(out_valid), 64'd0);
    tick();
    set_in(1'b0, N'(0), N'(0));
    @(negedge clk);
    check("post_handshake_busy", 64'(busy), 64'd1);
    wait_out("after_stall_out_timeout");
    check("prod_12x13", 64'(product), 64'd156);
    tick();

    // Reset while column 7 is being reduced.
    set_in(1'b1, N'(1000), N'(1000));
    tick();
    set_in(1'b0, N'(0), N'(0));
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_product", 64'(product), 64'd0);
    run_op(N'(5), N'(7), got, lat);
    check("prod_5x7", got, 64'd35);

    // pp_bits churn during BUSY must not affect the captured set.
    tick();
    set_in(1'b1, N'(600), N'(3));
    out_ready = 1'b1;
    tick();
    for (int c = 0; c < 15; c++) begin
      set_in(1'($urandom_range(0, 1)), N'($urandom_range(0, 1023)),
             N'($urandom_range(0, 1023)));
      tick();
    end
    set_in(1'b0, N'(0), N'(0));
    wait_out("churn_out_timeout");
    check("prod_600x3", 64'(product), 64'd1800);
    tick();

    // Back-to-back random operands with random consumer stalls.
    acc0     = n_acc;
    res0     = n_res;
    rnd_done = 1'b0;
    fork
      begin
        logic stuck;
        stuck = 1'b0;
        for (int k = 0; k < 1000 && !stuck; k++) begin
          logic acc;
          set_in(1'b1, N'($urandom_range(0, 1023)), N'($urandom_range(0, 1023)));
          acc = 1'b0;
          for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
              acc = 1'b1;
              break;
            end
          end
          if (!acc) begin
            check("rand_accept_timeout", 64'(in_ready), 64'd1);
            stuck = 1'b1;
          end
          @(posedge clk);
          #1;
        end
        set_in(1'b0, N'(0), N'(0));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    out_ready = 1'b1;
    for (int c = 0; c < 100 && n_res != n_acc; c++) @(negedge clk);
    check("rand_accepts", 64'(n_acc - acc0), 64'd1000);
    check("rand_results", 64'(n_res - res0), 64'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
